// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: bus widths common with instructionmem,
// the default reset PC, and the fetch FSM state encoding.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Halt only counts as complete once nothing is in flight and the skid is empty.
  function automatic logic [1:0] fetch_next_state(input logic halt,
                                                  input logic inflight,
                                                  input logic skid_full);
    if (!halt) return ST_RUN;
    if (!inflight && !skid_full) return ST_HALTED;
    return ST_DRAIN;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer that catches a returning instruction
// when decode stalls; flush drops the entry on a redirect.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int DATA_W = FETCH_DATA_W,
  parameter int ADDR_W = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_instr,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc
);

  // Occupancy flag; push and pop never coincide because a full skid blocks issue.
  always_ff @(posedge clk) begin
    if (rst || flush) valid <= 1'b0;
    else if (push)    valid <= 1'b1;
    else if (pop)     valid <= 1'b0;
  end

  // Payload capture, no reset needed on data.
  always_ff @(posedge clk) begin
    if (push) begin
      instr <= push_instr;
      pc    <= push_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one synchronous imem read per cycle,
// tags returning instructions with their PC and hands them to decode with
// a 1-entry skid for back-pressure, plus redirect flush and halt/drain.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int                PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic              halted
);

  logic [ADDR_W-1:0] pc_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] pc_p1;
  logic [1:0]        state;

  logic              skid_vld;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  logic              skid_push;
  logic              skid_pop;

  logic              issue;
  logic              fire;
  logic              take_resp;

  // Issue only when a returning response is guaranteed a place to land.
  assign fire      = out_valid && out_ready;
  assign issue     = !rst && !halt && !redirect_valid && !skid_vld &&
                     !(out_valid && !out_ready);
  assign imem_en   = issue;
  assign imem_addr = pc_p0;

  assign take_resp = vld_p1 && !skid_vld && (!out_valid || fire);
  assign skid_push = vld_p1 && !redirect_valid && out_valid && !fire;
  assign skid_pop  = fire && skid_vld;
  assign halted    = (state == ST_HALTED);

  fetch_skid_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (skid_push),
    .push_instr (imem_instr),
    .push_pc    (pc_p1),
    .pop        (skid_pop),
    .valid      (skid_vld),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // PC sequencing, in-flight tracking, decode output register and FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0     <= RESET_PC;
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      state     <= ST_RUN;
    end else begin
      // p0 -> p1: address issued now, its data returns at the next edge
      vld_p1 <= issue;
      if (issue) pc_p1 <= pc_p0;
      if (redirect_valid) pc_p0 <= redirect_pc;
      else if (issue)     pc_p0 <= pc_p0 + ADDR_W'(PC_STEP);

      // p1 -> out: response goes to output register, skid, or is discarded
      if (redirect_valid) begin
        out_valid <= 1'b0;
      end else if (skid_pop) begin
        out_valid <= 1'b1;
        out_instr <= skid_instr;
        out_pc    <= skid_pc;
      end else if (take_resp) begin
        out_valid <= 1'b1;
        out_instr <= imem_instr;
        out_pc    <= pc_p1;
      end else if (fire) begin
        out_valid <= 1'b0;
      end

      state <= fetch_next_state(halt, vld_p1, skid_vld);
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios, a queue-based model of
// issued-but-undelivered fetches checked every cycle, and literal spot checks.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        halted;

  // second instance starting at the top of the address space
  logic        w_imem_en;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_instr;
  logic        w_zero = 1'b0;
  logic [31:0] w_zpc  = 32'h0;
  logic        w_one  = 1'b1;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic        w_halted;

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
    .halted(halted)
  );

  instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .rst(rst), .imem_en(w_imem_en), .imem_addr(w_imem_addr),
    .imem_instr(w_imem_instr), .redirect_valid(w_zero),
    .redirect_pc(w_zpc), .halt(w_zero), .out_valid(w_out_valid),
    .out_instr(w_out_instr), .out_pc(w_out_pc), .out_ready(w_one),
    .halted(w_halted)
  );

  // instruction memories: word n holds n + 0x100, synchronous read
  always @(posedge clk) begin
    if (imem_en)   imem_instr   <= imem_addr + 32'h100;
    if (w_imem_en) w_imem_instr <= w_imem_addr + 32'h100;
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [31:0] pc;
    int          arr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] fired[$];
  logic [31:0] pc_m     = 32'h0;
  logic        halted_m = 1'b0;
  logic        rst_d    = 1'b0;
  int          cyc      = 0;
  int          arrived;
  int          unarr;
  logic        exp_valid;
  logic        exp_issue;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_imem_en", {31'b0, imem_en}, 32'h0);
      if (rst_d) begin
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
      end
      q.delete();
      pc_m     = 32'h0;
      halted_m = 1'b0;
    end else begin
      if (out_valid && out_ready) fired.push_back(out_pc);
      arrived = 0;
      unarr   = 0;
      foreach (q[i]) begin
        if (q[i].arr <= cyc) arrived++;
        else unarr++;
      end
      exp_valid = (arrived > 0);
      exp_issue = !halt && !redirect_valid &&
                  (arrived == 0 || (arrived == 1 && out_ready));
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_instr", out_instr, q[0].pc + 32'h100);
      end
      chk("imem_en", {31'b0, imem_en}, {31'b0, exp_issue});
      chk("imem_addr", imem_addr, pc_m);
      chk("halted", {31'b0, halted}, {31'b0, halted_m});

      if (exp_valid && out_ready) void'(q.pop_front());
      halted_m = halt && (unarr == 0) && (arrived < 2);
      if (redirect_valid) begin
        q.delete();
        pc_m = redirect_pc;
      end else if (exp_issue) begin
        q.push_back('{pc: pc_m, arr: cyc + 2});
        pc_m = pc_m + 32'h1;
      end
    end
    rst_d = rst;
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && out_pc == pc) found = 1;
      else step();
    end
    nvec++;
    if (!found) begin
      nfail++;
      $display("FAIL wait_out %h: not seen within 100 cycles", pc);
    end
  endtask

  task automatic wait_issue(input logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (imem_en && imem_addr == pc) found = 1;
      else step();
    end
    nvec++;
    if (!found) begin
      nfail++;
      $display("FAIL wait_issue %h: not seen within 100 cycles", pc);
    end
  endtask

  int n_pre;

  initial begin
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    out_ready = 1'b1;
    step(); step();
    rst = 1'b0;

    // reset release and streaming
    #1;
    chk("lit_c0_en", {31'b0, imem_en}, 32'h1);
    chk("lit_c0_addr", imem_addr, 32'h0);
    chk("lit_wrap_c0_addr", w_imem_addr, 32'hFFFF_FFFF);
    step(); #1;
    chk("lit_c1_addr", imem_addr, 32'h1);
    chk("lit_c1_valid", {31'b0, out_valid}, 32'h0);
    step(); #1;
    chk("lit_c2_valid", {31'b0, out_valid}, 32'h1);
    chk("lit_c2_pc", out_pc, 32'h0);
    chk("lit_c2_instr", out_instr, 32'h100);
    chk("lit_wrap_c2_pc", w_out_pc, 32'hFFFF_FFFF);
    chk("lit_wrap_c2_instr", w_out_instr, 32'h0000_00FF);
    step(); #1;
    chk("lit_c3_pc", out_pc, 32'h1);
    chk("lit_wrap_c3_pc", w_out_pc, 32'h0);
    chk("lit_wrap_c3_instr", w_out_instr, 32'h100);
    step();

    // back-pressure: stall decode for 5 cycles with pc 4 at the output
    wait_out(32'h4);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("lit_stall_en", {31'b0, imem_en}, 32'h0);
      chk("lit_stall_pc", out_pc, 32'h4);
      step();
    end
    out_ready = 1'b1;

    // redirect while 7 is firing and 8 is in flight
    wait_out(32'h7);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    #1;
    chk("lit_redir_en", {31'b0, imem_en}, 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("lit_redir_addr", imem_addr, 32'h40);
    chk("lit_redir_en1", {31'b0, imem_en}, 32'h1);
    chk("lit_redir_flush", {31'b0, out_valid}, 32'h0);

    // halt on the cycle 0x48 would issue
    wait_issue(32'h48);
    halt = 1'b1;
    #1;
    chk("lit_halt_en", {31'b0, imem_en}, 32'h0);
    for (int i = 0; i < 6; i++) step();
    #1;
    chk("lit_halted", {31'b0, halted}, 32'h1);
    chk("lit_halt_drained", {31'b0, out_valid}, 32'h0);
    halt = 1'b0;
    #1;
    chk("lit_resume_en", {31'b0, imem_en}, 32'h1);
    chk("lit_resume_addr", imem_addr, 32'h48);
    step();

    // reset with the skid full and out_valid high
    wait_out(32'h4C);
    out_ready = 1'b0;
    step(); step();
    n_pre = fired.size();
    rst = 1'b1;
    step(); #1;
    chk("lit_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("lit_rst_halted", {31'b0, halted}, 32'h0);
    chk("lit_rst_en", {31'b0, imem_en}, 32'h0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("lit_restart_en", {31'b0, imem_en}, 32'h1);
    chk("lit_restart_addr", imem_addr, 32'h0);
    wait_out(32'h3);
    step(); step();

    // delivered order: 0..7, then 0x40.. contiguous through the halt
    chk("lit_log_len", n_pre, 32'd20);
    for (int i = 0; i < n_pre; i++)
      chk("lit_log", fired[i], (i < 8) ? i : 32'h40 + (i - 8));
    if (fired.size() > n_pre) chk("lit_log_restart", fired[n_pre], 32'h0);
    else chk("lit_log_restart_len", fired.size(), n_pre + 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Fetch sequencer in front of the word-addressed instruction memory (`instructionmem`: 32-bit addr in, 32-bit instr out, synchronous read).
- Owns the PC and issues one read per cycle.
- Tags each returned instruction with its PC and hands it to decode over a valid/ready interface.
- Handles decode back-pressure (1-entry skid), branch redirect (flush) and halt.

Parameters:
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC loaded on reset.
- PC_STEP, 1, PC increment per fetch (memory is word-indexed).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_en  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  read address; equals pc register.
- imem_instr  in  DATA_W  read data, valid the cycle after imem_en was high.
- redirect_valid  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  ADDR_W  target PC.
- halt  in  1  level; stop issuing new fetches.
- out_valid  out  1  instruction available to decode.
- out_instr  out  DATA_W  fetched instruction.
- out_pc  out  ADDR_W  PC of out_instr.
- out_ready  in  1  decode accepts; transfer when out_valid & out_ready (fire).
- halted  out  1  halt in effect and pipeline drained.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0.
  - skid empty, inflight=0, halted=0.
  - imem_en=0 while rst high.
  - rst overrides redirect and halt.
- State machine:
  - RUN:
    - Issue when: halt=0 AND skid empty AND NOT (out_valid & !out_ready) AND redirect_valid=0.
    - On issue: imem_en=1, imem_addr=pc; next inflight=1, inflight_pc=pc; pc+=PC_STEP, modulo 2^ADDR_W (wrap, no flag).
    - Not issuing: imem_en=0, inflight cleared next cycle.
  - DRAIN: halt=1 with inflight or out/skid occupied. No issue; existing entries deliver normally.
  - HALTED: halt=1, inflight=0, skid empty. halted=1 (out_valid may still be 1 until fired). halt=0 returns to RUN next cycle.
- Latency and throughput:
  - Address issued in cycle c; out_valid first seen in cycle c+2.
  - Sustained 1 instruction/cycle while out_ready=1.
  - First issue in the first cycle after rst falls.
- Response routing at the edge ending cycle c+1 (inflight=1):
  - out empty or firing, and skid empty -> out register.
  - Otherwise -> skid.
  - On a fire with skid full, skid moves to out; no response can arrive that cycle because the issue rule prevents it.
  - A skid of depth 1 never overflows.
- Redirect (redirect_valid=1 in cycle t; highest priority after rst):
  - pc=redirect_pc at the edge.
  - out_valid=0, skid emptied.
  - A response landing at that edge is discarded.
  - No issue in t; first issue at redirect_pc in t+1.
  - A fire in t is still a valid transfer.
  - During halt: pc updated, state remains DRAIN/HALTED.
- Simultaneous events:
  - rst > redirect > halt > normal issue.
  - halt rising in the same cycle as an issue opportunity suppresses that issue.

Decomposition:
- Shared package/include `fetch_pkg`: state encoding (RUN, DRAIN, HALTED), default RESET_PC, ADDR_W/DATA_W constants shared with instructionmem.
- One natural sub-module: `fetch_skid_buf`, a 1-entry {instr, pc} buffer with flush input.

Test Plan:
- Reset/stream: rst 2 cycles, RESET_PC=0, memory[n]=n+0x100, out_ready=1 -> imem_addr 0,1,2… on consecutive cycles; out_valid first at cycle 2 after rst falls; out {pc,instr} = {0,0x100},{1,0x101},…; no gaps.
- Back-pressure: out_ready=0 for 5 cycles mid-stream at pc 4 -> at most one entry in skid, imem_en low during the stall; after release, pcs 4,5,6… delivered in order, none lost or duplicated.
- Redirect: redirect_valid pulse with redirect_pc=0x40 while pcs 7,8 are in flight -> 7/8 not delivered (unless 7 fired that cycle); next cycle imem_addr=0x40; out_pc sequence 0x40,0x41.
- Halt: assert halt at pc 10 -> issuing stops, pending instructions drain; halted=1 after drain; deassert -> resumes at exact next pc.
- Wrap: RESET_PC=0xFFFFFFFF -> pcs 0xFFFFFFFF, 0x00000000 delivered back to back.
- Reset mid-operation: rst asserted with skid full and out_valid=1 -> next cycle out_valid=0, halted=0, imem_en=0; restart from RESET_PC.
